// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit controllers.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through register FIFO; head is held in a register so it
// keeps its last value once the FIFO drains.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = UART_DATA_BITS
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       head_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [LW-1:0]    wr_ptr;
   logic [LW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    rd_idx;
   logic             push_ok_c;
   logic             pop_ok_c;

   // Pointers carry one extra MSB so full and empty differ.
   assign wr_idx    = wr_ptr[AW-1:0];
   assign rd_idx    = rd_ptr[AW-1:0];
   assign level_o   = wr_ptr - rd_ptr;
   assign empty_o   = (wr_ptr == rd_ptr);
   assign full_o    = (level_o == LW'(DEPTH));
   assign pop_ok_c  = pop_i & ~empty_o;
   assign push_ok_c = push_i & (~full_o | pop_ok_c);

   // Pointer advance and head register update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         head_o <= '0;
      end else begin
         if (push_ok_c) wr_ptr <= wr_ptr + LW'(1);
         if (pop_ok_c)  rd_ptr <= rd_ptr + LW'(1);
         if (pop_ok_c && (level_o > LW'(1))) begin
            head_o <= mem[rd_idx + AW'(1)];
         end else if (push_ok_c && (empty_o || pop_ok_c)) begin
            head_o <= data_i;
         end
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_ok_c) mem[wr_idx] <= data_i;
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receiver: input synchroniser, bit-timing FSM, sticky error flags
// and a small FWFT receive FIFO with a valid/ready read port.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4167,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        rx_i,
   output logic [7:0]                  rx_data_o,
   output logic                        rx_valid_o,
   input  logic                        rx_ready_i,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
   output logic                        busy_o,
   output logic                        frame_err_o,
   output logic                        overrun_o,
   input  logic                        err_clr_i
);

   localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
   localparam int unsigned HALF = CLKS_PER_BIT / 2;
   localparam int unsigned DW   = UART_DATA_BITS;
   localparam int unsigned IW   = $clog2(DW);

   rx_state_t     state;
   logic          rx_m;
   logic          rx_s;
   logic [CW-1:0] bit_cnt;
   logic [IW-1:0] bit_idx;
   logic [DW-1:0] shift_q;
   logic          stop_smp_c;
   logic          push_c;
   logic          pop_c;
   logic          ferr_set_c;
   logic          ovr_set_c;
   logic          fifo_full;
   logic          fifo_empty;

   // Two-flop synchroniser; idles high so reset does not look like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx_i;
         rx_s <= rx_m;
      end
   end

   assign stop_smp_c = (state == STOP) && (bit_cnt == CW'(CLKS_PER_BIT - 1));
   assign push_c     = stop_smp_c & rx_s;
   assign ferr_set_c = stop_smp_c & ~rx_s;
   assign pop_c      = rx_valid_o & rx_ready_i;
   assign ovr_set_c  = push_c & fifo_full & ~pop_c;
   assign rx_valid_o = ~fifo_empty;

   // Frame FSM: mid-bit sampling, LSB-first shift, busy tracks non-IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shift_q <= '0;
         busy_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state   <= START;
                  bit_cnt <= '0;
                  busy_o  <= 1'b1;
               end
            end
            START: begin
               if (bit_cnt == CW'(HALF - 1)) begin
                  bit_cnt <= '0;
                  if (!rx_s) begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end else begin
                     state  <= IDLE;
                     busy_o <= 1'b0;
                  end
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            DATA: begin
               if (bit_cnt == CW'(CLKS_PER_BIT - 1)) begin
                  bit_cnt <= '0;
                  shift_q <= {rx_s, shift_q[DW-1:1]};
                  bit_idx <= bit_idx + IW'(1);
                  if (bit_idx == IW'(DW - 1)) state <= STOP;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            STOP: begin
               if (stop_smp_c) begin
                  bit_cnt <= '0;
                  state   <= IDLE;
                  busy_o  <= 1'b0;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               bit_cnt <= '0;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

   // Sticky error flags; a new event in the clear cycle wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         if (ferr_set_c)     frame_err_o <= 1'b1;
         else if (err_clr_i) frame_err_o <= 1'b0;
         if (ovr_set_c)      overrun_o   <= 1'b1;
         else if (err_clr_i) overrun_o   <= 1'b0;
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_c),
      .data_i  (shift_q),
      .pop_i   (pop_c),
      .head_o  (rx_data_o),
      .level_o (fifo_level_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frame-level reference (queue + stop-sample timing)
// compared every cycle, plus directed literal expectations.
module tb_uart_rx_ctrl;

   localparam int unsigned CPB   = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned HALF  = CPB / 2;
   localparam int unsigned LW    = $clog2(DEPTH) + 1;
   localparam int          LAT   = 3 + int'(HALF) + 9 * int'(CPB);
   localparam int          FRAME = 10 * int'(CPB);

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          rx_i = 1'b1;
   logic          rx_ready_i = 1'b0;
   logic          err_clr_i = 1'b0;
   logic [7:0]    rx_data_o;
   logic          rx_valid_o;
   logic [LW-1:0] fifo_level_o;
   logic          busy_o;
   logic          frame_err_o;
   logic          overrun_o;

   uart_rx_ctrl #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_i         (rx_i),
      .rx_data_o    (rx_data_o),
      .rx_valid_o   (rx_valid_o),
      .rx_ready_i   (rx_ready_i),
      .fifo_level_o (fifo_level_o),
      .busy_o       (busy_o),
      .frame_err_o  (frame_err_o),
      .overrun_o    (overrun_o),
      .err_clr_i    (err_clr_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         done;
      logic [7:0] data;
      logic       stop;
   } ev_t;

   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         dd;
   int         d0;
   ev_t        pend[$];
   logic [7:0] mq[$];
   logic [7:0] m_head = 8'h00;
   bit         m_ferr = 1'b0;
   bit         m_ovr = 1'b0;
   bit         m_pop, m_push, m_fs, m_os;
   ev_t        m_ev;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: a byte whose frame started at cycle c completes at c+LAT.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mq.delete();
         pend.delete();
         m_head = 8'h00;
         m_ferr = 1'b0;
         m_ovr  = 1'b0;
      end else begin
         cyc++;
         m_pop  = rx_ready_i && (mq.size() > 0);
         m_push = 1'b0;
         m_fs   = 1'b0;
         m_os   = 1'b0;
         if (pend.size() > 0 && pend[0].done == cyc) begin
            m_ev = pend.pop_front();
            if (!m_ev.stop)                            m_fs   = 1'b1;
            else if (mq.size() < int'(DEPTH) || m_pop) m_push = 1'b1;
            else                                       m_os   = 1'b1;
         end
         if (m_pop)  void'(mq.pop_front());
         if (m_push) mq.push_back(m_ev.data);
         m_ferr = m_fs | (m_ferr & ~err_clr_i);
         m_ovr  = m_os | (m_ovr & ~err_clr_i);
         if (mq.size() > 0) m_head = mq[0];
      end
   end

   // Per-cycle comparison against the reference.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         check("valid",     32'(rx_valid_o),   32'(mq.size() != 0));
         check("level",     32'(fifo_level_o), 32'(mq.size()));
         check("data",      32'(rx_data_o),    32'(m_head));
         check("frame_err", 32'(frame_err_o),  32'(m_ferr));
         check("overrun",   32'(overrun_o),    32'(m_ovr));
      end
   end

   // Drives one frame starting now (called at a negedge); returns stop-sample cycle.
   task automatic send(input logic [7:0] d, input logic stop, input int gap, output int done);
      ev_t e;
      rx_i   = 1'b0;
      done   = cyc + LAT;
      e.done = done;
      e.data = d;
      e.stop = stop;
      pend.push_back(e);
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_i = d[i];
         repeat (CPB) @(negedge clk);
      end
      rx_i = stop;
      repeat (CPB) @(negedge clk);
      rx_i = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic pop_one();
      rx_ready_i = 1'b1;
      @(negedge clk);
      rx_ready_i = 1'b0;
   endtask

   task automatic clr_pulse();
      err_clr_i = 1'b1;
      @(negedge clk);
      err_clr_i = 1'b0;
   endtask

   task automatic drain();
      rx_ready_i = 1'b1;
      repeat (DEPTH + 2) @(negedge clk);
      rx_ready_i = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(rx_valid_o),   32'd0);
      check({tag, "_level"}, 32'(fifo_level_o), 32'd0);
      check({tag, "_data"},  32'(rx_data_o),    32'd0);
      check({tag, "_busy"},  32'(busy_o),       32'd0);
      check({tag, "_ferr"},  32'(frame_err_o),  32'd0);
      check({tag, "_ovr"},   32'(overrun_o),    32'd0);
   endtask

   initial begin
      #(30000 * 10);
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2 rst_n = 1'b0;
      #1 check_all_zero("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Two back-to-back bytes, then pop them in order.
      send(8'h3D, 1'b1, 0, dd);
      send(8'h0F, 1'b1, 2 * int'(CPB), dd);
      check("b2b_level", 32'(fifo_level_o), 32'd2);
      check("b2b_head0", 32'(rx_data_o), 32'h3D);
      pop_one();
      check("b2b_head1", 32'(rx_data_o), 32'h0F);
      check("b2b_level1", 32'(fifo_level_o), 32'd1);
      pop_one();
      check("b2b_empty", 32'(rx_valid_o), 32'd0);
      check("b2b_noflag", 32'({frame_err_o, overrun_o}), 32'd0);

      // Three-cycle low glitch is rejected at the half-bit point.
      rx_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("glitch_busy_pre", 32'(busy_o), 32'd0);
      @(negedge clk);
      rx_i = 1'b1;
      check("glitch_busy_rise", 32'(busy_o), 32'd1);
      repeat (3) @(negedge clk);
      check("glitch_busy_hold", 32'(busy_o), 32'd1);
      @(negedge clk);
      check("glitch_busy_fall", 32'(busy_o), 32'd0);
      repeat (2 * CPB) @(negedge clk);
      check("glitch_level", 32'(fifo_level_o), 32'd0);
      check("glitch_ferr", 32'(frame_err_o), 32'd0);

      // Framing error, clear, then set and clear in the same cycle.
      send(8'hA5, 1'b0, 3 * int'(CPB), dd);
      check("ferr_set", 32'(frame_err_o), 32'd1);
      check("ferr_level", 32'(fifo_level_o), 32'd0);
      clr_pulse();
      check("ferr_clr", 32'(frame_err_o), 32'd0);
      fork
         send(8'hA5, 1'b0, 3 * int'(CPB), dd);
         begin
            repeat (LAT - 1) @(negedge clk);
            err_clr_i = 1'b1;
            @(negedge clk);
            err_clr_i = 1'b0;
         end
      join
      check("ferr_set_wins", 32'(frame_err_o), 32'd1);
      clr_pulse();

      // Overrun on the fifth byte into a full FIFO.
      for (int b = 1; b <= 4; b++) send(8'(b), 1'b1, 0, dd);
      send(8'h05, 1'b1, 2 * int'(CPB), dd);
      check("ovr_level", 32'(fifo_level_o), 32'd4);
      check("ovr_flag", 32'(overrun_o), 32'd1);
      check("ovr_head", 32'(rx_data_o), 32'h01);
      drain();
      clr_pulse();
      check("ovr_clr", 32'(overrun_o), 32'd0);

      // Same, but a pop coincides with the fifth push.
      for (int b = 1; b <= 4; b++) send(8'(b), 1'b1, 0, dd);
      fork
         send(8'h05, 1'b1, 2 * int'(CPB), dd);
         begin
            repeat (LAT - 1) @(negedge clk);
            rx_ready_i = 1'b1;
            @(negedge clk);
            rx_ready_i = 1'b0;
         end
      join
      check("pp_level", 32'(fifo_level_o), 32'd4);
      check("pp_ovr", 32'(overrun_o), 32'd0);
      check("pp_head", 32'(rx_data_o), 32'h02);
      drain();

      // Reset during bit 4 of 0x3D, with a byte already buffered.
      send(8'h11, 1'b1, 0, dd);
      rx_i = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx_i = d0[0] ^ (8'h3D >> i) & 1'b1 ? 1'b1 : 1'b0;
         repeat (CPB) @(negedge clk);
      end
      rx_i = 1'b1;
      repeat (HALF) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midreset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      send(8'h0F, 1'b1, 2 * int'(CPB), dd);
      check("post_reset_head", 32'(rx_data_o), 32'h0F);
      check("post_reset_level", 32'(fifo_level_o), 32'd1);
      pop_one();

      // Consumer always ready: each byte valid for exactly one cycle.
      rx_ready_i = 1'b1;
      fork
         begin
            send(8'h00, 1'b1, 0, dd);
            send(8'hFF, 1'b1, 2 * int'(CPB), dd);
         end
         begin
            repeat (LAT - 1) @(negedge clk);
            check("rdy_pre0", 32'(rx_valid_o), 32'd0);
            @(negedge clk);
            check("rdy_v0", 32'(rx_valid_o), 32'd1);
            check("rdy_d0", 32'(rx_data_o), 32'h00);
            @(negedge clk);
            check("rdy_post0", 32'(rx_valid_o), 32'd0);
            repeat (FRAME - 2) @(negedge clk);
            check("rdy_pre1", 32'(rx_valid_o), 32'd0);
            @(negedge clk);
            check("rdy_v1", 32'(rx_valid_o), 32'd1);
            check("rdy_d1", 32'(rx_data_o), 32'hFF);
            @(negedge clk);
            check("rdy_post1", 32'(rx_valid_o), 32'd0);
         end
      join
      rx_ready_i = 1'b0;
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial d0 = 0;

endmodule
